// File: rtl/pts_trigger_sequencer.sv
// Table-driven trigger sequencer: times a programmable list of step durations
// and pulses oTrigger at the end of each step, optionally looping forever.
module pts_trigger_sequencer #(
    parameter int MAX_STEP = 256,
    parameter int CNT_W    = 32
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iSET_DUR_FLAG,
    input  logic [7:0]       iSET_DUR_ADDR,
    input  logic [CNT_W-1:0] iSET_DUR,
    input  logic             iSET_LEN_FLAG,
    input  logic [8:0]       iSET_LEN,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic             iLoop,
    output logic             oTrigger,
    output logic [7:0]       oStep,
    output logic             oBusy,
    output logic             oDone,
    output logic             oWrErr
);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    localparam logic [8:0]       MAX_LEN = 9'(MAX_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       step_q, step_d;
    logic [8:0]       len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trig_q, trig_d;
    logic             done_q, done_d;
    logic             wrerr_q, wrerr_d;

    logic [CNT_W-1:0] mem_q [0:MAX_STEP-1];
    logic [CNT_W-1:0] rd_q;
    logic [7:0]       rd_addr;
    logic             mem_we;
    logic             busy;
    logic             step_last;
    logic [CNT_W-1:0] load_val;

    function automatic logic [7:0] next_step(input logic [7:0] s, input logic [8:0] len);
        next_step = ({1'b0, s} == len - 9'd1) ? 8'd0 : s + 8'd1;
    endfunction

    assign busy      = (state_q == LOAD) || (state_q == COUNT);
    assign step_last = ({1'b0, step_q} == len_q - 9'd1);
    assign load_val  = (rd_q == '0) ? CNT_ONE : rd_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        done_d  = 1'b0;
        wrerr_d = busy && (iSET_DUR_FLAG || iSET_LEN_FLAG);
        mem_we  = 1'b0;

        if (state_q == IDLE) begin
            mem_we = iSET_DUR_FLAG;
            if (iSET_LEN_FLAG) begin
                len_d = (iSET_LEN > MAX_LEN) ? MAX_LEN : iSET_LEN;
            end
        end

        case (state_q)
            IDLE: begin
                if (iStart && (len_q != 9'd0)) begin
                    state_d = LOAD;
                    step_d  = 8'd0;
                end
            end
            LOAD: begin
                cnt_d   = load_val;
                state_d = COUNT;
            end
            COUNT: begin
                if (cnt_q <= CNT_ONE) begin
                    trig_d = 1'b1;
                    if (step_last && !iLoop) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        step_d = next_step(step_q, len_q);
                        cnt_d  = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (iAbort) begin
            state_d = IDLE;
            step_d  = 8'd0;
            cnt_d   = '0;
            trig_d  = 1'b0;
            done_d  = 1'b0;
        end

        // Prefetch the duration for whichever step follows the one about to be timed,
        // so a reload at the trigger edge never waits on the registered RAM read.
        rd_addr = (state_q == IDLE) ? 8'd0 : next_step(step_d, len_q);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= IDLE;
            step_q  <= 8'd0;
            len_q   <= 9'd0;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            wrerr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            wrerr_q <= wrerr_d;
        end
    end

    // Duration table is deliberately left out of reset so programmed values survive it.
    always_ff @(posedge iClk) begin
        if (mem_we) begin
            mem_q[iSET_DUR_ADDR] <= iSET_DUR;
        end
        rd_q <= mem_q[rd_addr];
    end

    assign oTrigger = trig_q;
    assign oStep    = step_q;
    assign oBusy    = busy;
    assign oDone    = done_q;
    assign oWrErr   = wrerr_q;

endmodule

// File: tb/tb_pts_trigger_sequencer.sv
// Scoreboard bench for pts_trigger_sequencer: expected trigger/done events are queued
// with their cycle and step when a run is started, and popped as the DUT emits them.
module tb_pts_trigger_sequencer;

    logic        iClk;
    logic        iRst;
    logic        iSET_DUR_FLAG;
    logic [7:0]  iSET_DUR_ADDR;
    logic [31:0] iSET_DUR;
    logic        iSET_LEN_FLAG;
    logic [8:0]  iSET_LEN;
    logic        iStart;
    logic        iAbort;
    logic        iLoop;
    logic        oTrigger;
    logic [7:0]  oStep;
    logic        oBusy;
    logic        oDone;
    logic        oWrErr;

    pts_trigger_sequencer dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iSET_DUR_FLAG (iSET_DUR_FLAG),
        .iSET_DUR_ADDR (iSET_DUR_ADDR),
        .iSET_DUR      (iSET_DUR),
        .iSET_LEN_FLAG (iSET_LEN_FLAG),
        .iSET_LEN      (iSET_LEN),
        .iStart        (iStart),
        .iAbort        (iAbort),
        .iLoop         (iLoop),
        .oTrigger      (oTrigger),
        .oStep         (oStep),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oWrErr        (oWrErr)
    );

    typedef struct {
        int cyc;
        bit done;
        int step;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge iClk) begin
        ev_t e;
        if (oTrigger || oDone) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_event", {30'd0, oDone, oTrigger}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("cycle %0d: %s step=%0d (expected cycle %0d step %0d)",
                         cyc, oDone ? "done" : "trigger", oStep, e.cyc, e.step);
                check_val("event_cycle", cyc, e.cyc);
                check_val("event_kind", {31'd0, oDone}, {31'd0, e.done});
                check_val("event_step", {24'd0, oStep}, e.step);
            end
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_ev(input int c, input bit d, input int s);
        ev_t e;
        e.cyc  = c;
        e.done = d;
        e.step = s;
        exp_q.push_back(e);
    endtask

    task automatic write_dur(input int a, input int d);
        iSET_DUR_FLAG = 1'b1;
        iSET_DUR_ADDR = a[7:0];
        iSET_DUR      = d;
        tick();
        iSET_DUR_FLAG = 1'b0;
    endtask

    task automatic write_len(input int l);
        iSET_LEN_FLAG = 1'b1;
        iSET_LEN      = l[8:0];
        tick();
        iSET_LEN_FLAG = 1'b0;
    endtask

    // Starts a run and returns the edge number at which iStart is sampled.
    task automatic start_run(output int s);
        iStart = 1'b1;
        s = cyc + 1;
        tick();
        iStart = 1'b0;
    endtask

    // Durations {5,2,4}, three steps, no loop.
    task automatic push_run_a(input int s);
        push_ev(s + 6, 1'b0, 1);
        push_ev(s + 8, 1'b0, 2);
        push_ev(s + 12, 1'b0, 2);
        push_ev(s + 13, 1'b1, 2);
    endtask

    initial begin
        int s;
        iRst = 1'b0;
        iSET_DUR_FLAG = 1'b0;
        iSET_DUR_ADDR = 8'd0;
        iSET_DUR = 32'd0;
        iSET_LEN_FLAG = 1'b0;
        iSET_LEN = 9'd0;
        iStart = 1'b0;
        iAbort = 1'b0;
        iLoop = 1'b0;
        #1;
        check_val("rst_trigger", {31'd0, oTrigger}, 32'd0);
        check_val("rst_step", {24'd0, oStep}, 32'd0);
        check_val("rst_busy", {31'd0, oBusy}, 32'd0);
        check_val("rst_done", {31'd0, oDone}, 32'd0);
        check_val("rst_wrerr", {31'd0, oWrErr}, 32'd0);
        tick(); tick();
        iRst = 1'b1;
        tick();

        // len is 0 after reset: a start request must do nothing
        start_run(s);
        @(negedge iClk);
        check_val("len0_busy", {31'd0, oBusy}, 32'd0);
        repeat (10) tick();

        write_dur(0, 5);
        write_dur(1, 2);
        write_dur(2, 4);
        write_len(3);

        // Run A with rejected writes injected while busy
        start_run(s);
        push_run_a(s);
        @(negedge iClk);
        check_val("load_busy", {31'd0, oBusy}, 32'd1);
        wait_until(s + 3);
        iSET_DUR_FLAG = 1'b1;
        iSET_DUR_ADDR = 8'd1;
        iSET_DUR = 32'd7;
        tick();
        iSET_DUR_FLAG = 1'b0;
        @(negedge iClk);
        check_val("wrerr_dur", {31'd0, oWrErr}, 32'd1);
        tick();
        iSET_LEN_FLAG = 1'b1;
        iSET_LEN = 9'd1;
        tick();
        iSET_LEN_FLAG = 1'b0;
        @(negedge iClk);
        check_val("wrerr_len", {31'd0, oWrErr}, 32'd1);
        tick();
        @(negedge iClk);
        check_val("wrerr_pulse_end", {31'd0, oWrErr}, 32'd0);
        wait_until(s + 16);
        check_val("runA_busy_end", {31'd0, oBusy}, 32'd0);
        check_val("runA_step_end", {24'd0, oStep}, 32'd2);
        check_val("runA_pending", exp_q.size(), 32'd0);

        // Same timing again proves table and len survived the rejected writes
        start_run(s);
        push_run_a(s);
        wait_until(s + 16);
        check_val("runA2_pending", exp_q.size(), 32'd0);

        // Abort on the edge the second trigger would fire
        start_run(s);
        push_ev(s + 6, 1'b0, 1);
        wait_until(s + 7);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        @(negedge iClk);
        check_val("abort_step", {24'd0, oStep}, 32'd0);
        check_val("abort_busy", {31'd0, oBusy}, 32'd0);
        check_val("abort_trigger", {31'd0, oTrigger}, 32'd0);
        repeat (15) tick();

        // Start together with abort in IDLE stays idle
        iStart = 1'b1;
        iAbort = 1'b1;
        tick();
        iStart = 1'b0;
        iAbort = 1'b0;
        @(negedge iClk);
        check_val("start_abort_busy", {31'd0, oBusy}, 32'd0);
        repeat (15) tick();
        check_val("abort_pending", exp_q.size(), 32'd0);

        // Reset during step 1 of a run
        start_run(s);
        push_run_a(s);
        wait_until(s + 7);
        check_val("pre_reset_step", {24'd0, oStep}, 32'd1);
        #2;
        iRst = 1'b0;
        #1;
        check_val("midrst_trigger", {31'd0, oTrigger}, 32'd0);
        check_val("midrst_step", {24'd0, oStep}, 32'd0);
        check_val("midrst_busy", {31'd0, oBusy}, 32'd0);
        check_val("midrst_done", {31'd0, oDone}, 32'd0);
        exp_q.delete();
        tick(); tick();
        iRst = 1'b1;
        repeat (15) tick();
        check_val("post_rst_idle", {31'd0, oBusy}, 32'd0);
        write_len(3);
        start_run(s);
        push_run_a(s);
        wait_until(s + 16);
        check_val("rerun_pending", exp_q.size(), 32'd0);

        // Looping two-step sequence {3,0}
        write_dur(0, 3);
        write_dur(1, 0);
        write_len(2);
        iLoop = 1'b1;
        start_run(s);
        for (int k = 0; k < 3; k++) begin
            push_ev(s + 4 + 4 * k, 1'b0, 1);
            push_ev(s + 5 + 4 * k, 1'b0, 0);
        end
        wait_until(s + 13);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        iLoop = 1'b0;
        @(negedge iClk);
        check_val("loop_abort_busy", {31'd0, oBusy}, 32'd0);
        repeat (10) tick();
        check_val("loop_pending", exp_q.size(), 32'd0);

        // Oversized length saturates to 256; every duration 1
        for (int a = 0; a < 256; a++) write_dur(a, 1);
        write_len(300);
        start_run(s);
        for (int k = 0; k < 256; k++) push_ev(s + 2 + k, 1'b0, (k < 255) ? k + 1 : 255);
        push_ev(s + 258, 1'b1, 255);
        wait_until(s + 270);
        check_val("sat_step_end", {24'd0, oStep}, 32'd255);
        check_val("sat_pending", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
